// File: rtl/rf_pkg.sv
// Shared widths, register count and the write-request record for the
// register-file write-port arbiter.
package rf_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_ADDR_W   = 3;
  localparam int RF_NUM_REGS = 7;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wr_req_t;

  // Addresses at or above the implemented register count are dropped.
  function automatic logic addr_legal(input logic [RF_ADDR_W-1:0] a);
    return 32'(a) < 32'(RF_NUM_REGS);
  endfunction

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Requester handshakes, register-file write port and hazard scoreboard
// bundled for the write-port arbiter.
interface rf_wr_arbiter_if;
  import rf_pkg::*;

  logic                   req0_valid;
  logic                   req0_ready;
  logic [RF_ADDR_W-1:0]   req0_addr;
  logic [RF_DATA_W-1:0]   req0_data;
  logic                   req1_valid;
  logic                   req1_ready;
  logic [RF_ADDR_W-1:0]   req1_addr;
  logic [RF_DATA_W-1:0]   req1_data;
  logic                   reg_wr_en;
  logic [RF_ADDR_W-1:0]   reg_wr_addr;
  logic [RF_DATA_W-1:0]   reg_wr_data;
  logic [RF_NUM_REGS-1:0] busy;
  logic                   err_bad_addr;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output reg_wr_en, reg_wr_addr, reg_wr_data, busy, err_bad_addr
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  reg_wr_en, reg_wr_addr, reg_wr_data, busy, err_bad_addr
  );

endinterface

// File: rtl/rf_wr_arbiter_fifo.sv
// DEPTH-entry synchronous FIFO for one writeback requester; exposes each
// slot's occupancy and address so the top can build the busy scoreboard.
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_push,
  input  wr_req_t                              i_data,
  input  logic                                 i_pop,
  output logic                                 o_full,
  output logic                                 o_empty,
  output wr_req_t                              o_head,
  output logic [DEPTH-1:0]                     o_ent_valid,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]      o_ent_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wr_req_t           r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  w_off [DEPTH];

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A slot is occupied when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_off[i]       = PTR_W'(i) - r_rd_ptr;
      o_ent_valid[i] = ({1'b0, w_off[i]} < r_cnt);
      o_ent_addr[i]  = r_mem[i].addr;
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: two buffered writeback requesters, one
// registered write per cycle, pending-write scoreboard. RF_WR_ARB_RR_EN selects round-robin.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rf_wr_arbiter_if.slave        bus
);

  localparam int DATA_W   = RF_DATA_W;
  localparam int ADDR_W   = RF_ADDR_W;
  localparam int NUM_REGS = RF_NUM_REGS;

  logic                              w_full0, w_empty0, w_push0, w_gnt0;
  logic                              w_full1, w_empty1, w_push1, w_gnt1;
  wr_req_t                           w_in0, w_in1, w_head0, w_head1, w_sel;
  logic [DEPTH-1:0]                  w_ev0, w_ev1;
  logic [DEPTH-1:0][ADDR_W-1:0]      w_ea0, w_ea1;
  logic                              w_pop, w_legal;
  logic                              r_wr_en, r_err;
  logic [ADDR_W-1:0]                 r_wr_addr;
  logic [DATA_W-1:0]                 r_wr_data;
  logic [NUM_REGS-1:0]               w_busy;

  assign bus.req0_ready = !w_full0;
  assign bus.req1_ready = !w_full1;
  assign w_push0 = bus.req0_valid && !w_full0;
  assign w_push1 = bus.req1_valid && !w_full1;
  assign w_in0   = {bus.req0_addr, bus.req0_data};
  assign w_in1   = {bus.req1_addr, bus.req1_data};

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .i_push(w_push0), .i_data(w_in0), .i_pop(w_gnt0),
    .o_full(w_full0), .o_empty(w_empty0), .o_head(w_head0),
    .o_ent_valid(w_ev0), .o_ent_addr(w_ea0)
  );

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .i_push(w_push1), .i_data(w_in1), .i_pop(w_gnt1),
    .o_full(w_full1), .o_empty(w_empty1), .o_head(w_head1),
    .o_ent_valid(w_ev1), .o_ent_addr(w_ea1)
  );

`ifdef RF_WR_ARB_RR_EN
  logic r_prio1;  // 1: FIFO1 wins the next contended cycle

  assign w_gnt0 = !w_empty0 && (w_empty1 || !r_prio1);
  assign w_gnt1 = !w_empty1 && (w_empty0 || r_prio1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_prio1 <= 1'b0;
    else if (w_gnt0) r_prio1 <= 1'b1;
    else if (w_gnt1) r_prio1 <= 1'b0;
  end
`else
  assign w_gnt0 = !w_empty0;
  assign w_gnt1 = w_empty0 && !w_empty1;
`endif

  assign w_pop   = w_gnt0 || w_gnt1;
  assign w_sel   = w_gnt1 ? w_head1 : w_head0;
  assign w_legal = addr_legal(w_sel.addr);

  // Illegal entries are consumed but leave the write port address/data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_err     <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_pop && w_legal;
      r_err   <= w_pop && !w_legal;
      if (w_pop && w_legal) begin
        r_wr_addr <= w_sel.addr;
        r_wr_data <= w_sel.data;
      end
    end
  end

  always_comb begin
    w_busy = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_ev0[e] && (w_ea0[e] == ADDR_W'(r))) w_busy[r] = 1'b1;
        if (w_ev1[e] && (w_ea1[e] == ADDR_W'(r))) w_busy[r] = 1'b1;
      end
      if (r_wr_en && (r_wr_addr == ADDR_W'(r))) w_busy[r] = 1'b1;
    end
  end

  assign bus.reg_wr_en    = r_wr_en;
  assign bus.reg_wr_addr  = r_wr_addr;
  assign bus.reg_wr_data  = r_wr_data;
  assign bus.err_bad_addr = r_err;
  assign bus.busy         = w_busy;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: directed stimulus queues expected writes,
// a negedge monitor retires them against the write port.
module tb_rf_wr_arbiter;
  import rf_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_wr_arbiter_if bus ();

  rf_wr_arbiter #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          err;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  bit   mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write or error pulse retires the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_on && rst_n && (bus.reg_wr_en || bus.err_bad_addr)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'({bus.err_bad_addr, bus.reg_wr_en}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_wr_en", 32'(bus.reg_wr_en),    32'(!e.err));
        chk("sb_err",   32'(bus.err_bad_addr), 32'(e.err));
        chk("sb_addr",  32'(bus.reg_wr_addr),  32'(e.addr));
        chk("sb_data",  32'(bus.reg_wr_data),  32'(e.data));
      end
    end
  end

  task automatic expect_wr(input bit err, input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    e.err = err; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Present one request and hold it until accepted; returns 1 time unit after the push edge.
  task automatic drive(input bit port, input logic [2:0] a, input logic [15:0] d);
    int budget = 50;
    bit ok = 1'b0;
    if (port) begin bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_data = d; end
    else      begin bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_data = d; end
    while (!ok && budget > 0) begin
      @(negedge clk);
      ok = port ? bus.req1_ready : bus.req0_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    if (!ok) chk("push_timeout", 32'(ok), 32'd1);
    if (port) bus.req1_valid = 1'b0;
    else      bus.req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 100;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wr_en",   32'(bus.reg_wr_en),    32'd0);
    chk("rst_wr_addr", 32'(bus.reg_wr_addr),  32'd0);
    chk("rst_wr_data", 32'(bus.reg_wr_data),  32'd0);
    chk("rst_busy",    32'(bus.busy),         32'd0);
    chk("rst_err",     32'(bus.err_bad_addr), 32'd0);
    chk("rst_ready0",  32'(bus.req0_ready),   32'd1);
    chk("rst_ready1",  32'(bus.req1_ready),   32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_on = 1'b1;

    // Single write, exact latency and busy window
    expect_wr(1'b0, 3'd3, 16'h1234);
    drive(1'b0, 3'd3, 16'h1234);
    @(negedge clk);
    chk("t1_busy_c1",  32'(bus.busy),      32'h08);
    chk("t1_wr_en_c1", 32'(bus.reg_wr_en), 32'd0);
    @(negedge clk);
    chk("t1_busy_c2",  32'(bus.busy),      32'h08);
    chk("t1_wr_en_c2", 32'(bus.reg_wr_en), 32'd1);
    @(negedge clk);
    chk("t1_busy_c3",  32'(bus.busy),      32'h00);
    chk("t1_wr_en_c3", 32'(bus.reg_wr_en), 32'd0);
    wait_drain();

    // Illegal address: error pulse, address/data hold the last legal write
    expect_wr(1'b1, 3'd3, 16'h1234);
    drive(1'b0, 3'd7, 16'hdead);
    @(negedge clk);
    chk("t4_busy_c1", 32'(bus.busy),         32'h00);
    @(negedge clk);
    chk("t4_err_c2",   32'(bus.err_bad_addr), 32'd1);
    chk("t4_wr_en_c2", 32'(bus.reg_wr_en),    32'd0);
    chk("t4_busy_c2",  32'(bus.busy),         32'h00);
    @(negedge clk);
    chk("t4_err_c3",   32'(bus.err_bad_addr), 32'd0);
    wait_drain();

    // Same register back-to-back
    expect_wr(1'b0, 3'd5, 16'h0001);
    expect_wr(1'b0, 3'd5, 16'h0002);
    drive(1'b0, 3'd5, 16'h0001);
    drive(1'b0, 3'd5, 16'h0002);
    @(negedge clk);
    chk("t6_busy_c2", 32'(bus.busy), 32'h20);
    @(negedge clk);
    chk("t6_busy_c3", 32'(bus.busy), 32'h20);
    @(negedge clk);
    chk("t6_busy_c4", 32'(bus.busy), 32'h00);
    wait_drain();

    // Contention: both requesters push every cycle
`ifdef RF_WR_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      expect_wr(1'b0, 3'd1, 16'hA000 + 16'(k));
      expect_wr(1'b0, 3'd2, 16'hB000 + 16'(k));
    end
`else
    for (int k = 0; k < 4; k++) expect_wr(1'b0, 3'd1, 16'hA000 + 16'(k));
    for (int k = 0; k < 4; k++) expect_wr(1'b0, 3'd2, 16'hB000 + 16'(k));
`endif
    fork
      begin
        for (int k = 0; k < 4; k++) drive(1'b0, 3'd1, 16'hA000 + 16'(k));
      end
      begin
        for (int j = 0; j < 4; j++) drive(1'b1, 3'd2, 16'hB000 + 16'(j));
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef RF_WR_ARB_RR_EN
        chk("t2_ready1_c3", 32'(bus.req1_ready), 32'd1);
`else
        chk("t2_ready1_c3", 32'(bus.req1_ready), 32'd0);
`endif
        chk("t2_busy_c3", 32'(bus.busy), 32'h06);
      end
    join
    wait_drain();

    // Reset mid-operation with both queues loaded
    mon_on = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd4; bus.req0_data = 16'h0444;
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd6; bus.req1_data = 16'h0666;
    repeat (3) @(posedge clk);
    #2;
    chk("t5_busy_pre", 32'(bus.busy != 0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_wr_en_rst",  32'(bus.reg_wr_en),    32'd0);
    chk("t5_busy_rst",   32'(bus.busy),         32'd0);
    chk("t5_err_rst",    32'(bus.err_bad_addr), 32'd0);
    chk("t5_addr_rst",   32'(bus.reg_wr_addr),  32'd0);
    chk("t5_ready0_rst", 32'(bus.req0_ready),   32'd1);
    chk("t5_ready1_rst", 32'(bus.req1_ready),   32'd1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    mon_on = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_no_stale_wr", 32'(bus.reg_wr_en), 32'd0);
      chk("t5_no_stale_busy", 32'(bus.busy), 32'd0);
    end

    wait_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
